// File: rtl/alu_wide_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_wide_seq
//  Purpose  : Issues one wide (16*NUM_SLICES-bit) operation to a 16-bit
//             datapath ALU, one slice per cycle, least-significant first.
//             Each slice's carry_out is chained into the next slice's
//             carry_in. All slice results are collected into the response.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             req_*             - valid/ready request (operands, sel, mode, cin)
//             alu_*             - drive side and return side of the 16-bit ALU
//             rsp_*             - valid/ready response (result, carry, equal)
//  Options  : ALU_SEQ_PIPE_EN   - when defined, a new request may be accepted
//                                 on the same edge that the response completes
//  Revision : 1.0 - initial release
// ============================================================================
module alu_wide_seq #(
  parameter int NUM_SLICES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  // request side
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [16*NUM_SLICES-1:0]   req_a,
  input  logic [16*NUM_SLICES-1:0]   req_b,
  input  logic [3:0]                 req_sel,
  input  logic                       req_mode,
  input  logic                       req_carry_in,
  // ALU drive side
  output logic                       alu_carry_in,
  output logic [15:0]                alu_in_a,
  output logic [15:0]                alu_in_b,
  output logic [3:0]                 alu_sel,
  output logic                       alu_mode,
  // ALU return side (combinational in the same cycle)
  input  logic                       alu_carry_out,
  input  logic                       alu_compare,
  input  logic [15:0]                alu_result,
  // response side
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [16*NUM_SLICES-1:0]   rsp_result,
  output logic                       rsp_carry_out,
  output logic                       rsp_equal
);

  localparam int c_W     = 16 * NUM_SLICES;
  localparam int c_IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_SLICES - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_W-1:0]       r_a;
  logic [c_W-1:0]       r_b;
  logic [3:0]           r_sel;
  logic                 r_mode;
  logic                 r_carry;
  logic                 r_eq;
  logic [15:0]          r_res [NUM_SLICES];

  logic [15:0]          w_a_slice [NUM_SLICES];
  logic [15:0]          w_b_slice [NUM_SLICES];
  logic                 w_accept;
  logic                 w_last;

  // Slice views of the captured operands, and packing of the result slices.
  for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
    assign w_a_slice[gi]               = r_a[16*gi +: 16];
    assign w_b_slice[gi]               = r_b[16*gi +: 16];
    assign rsp_result[16*gi +: 16]     = r_res[gi];
  end

  assign rsp_carry_out = r_carry;
  assign rsp_equal     = r_eq;
  assign w_last        = (r_idx == c_LAST_IDX);

  // --------------------------------------------------------------------------
  // State register and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_mode  <= 1'b0;
      r_carry <= 1'b0;
      r_eq    <= 1'b0;
      for (int i = 0; i < NUM_SLICES; i++) begin
        r_res[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a     <= req_a;
        r_b     <= req_b;
        r_sel   <= req_sel;
        r_mode  <= req_mode;
        r_idx   <= '0;
        r_carry <= req_carry_in;
        r_eq    <= 1'b1;
      end else if (r_state == ST_RUN) begin
        r_res[r_idx] <= alu_result;
        r_carry      <= alu_carry_out;
        r_eq         <= r_eq & alu_compare;
        // idx parks on the last slice through DONE; the next accept clears it.
        if (!w_last) begin
          r_idx <= r_idx + c_IDX_ONE;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs. Everything is forced inactive while rst is high so
  // the block presents a quiet interface during the reset cycle itself.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    alu_carry_in = 1'b0;
    alu_in_a     = '0;
    alu_in_b     = '0;
    alu_sel      = '0;
    alu_mode     = 1'b0;

    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end

        ST_RUN: begin
          alu_in_a     = w_a_slice[r_idx];
          alu_in_b     = w_b_slice[r_idx];
          alu_sel      = r_sel;
          alu_mode     = r_mode;
          alu_carry_in = r_carry;
          if (w_last) begin
            w_state_nxt = ST_DONE;
          end
        end

        ST_DONE: begin
          rsp_valid = 1'b1;
`ifdef ALU_SEQ_PIPE_EN
          // Response hand-off and the next request share the same edge.
          req_ready = rsp_ready;
          if (rsp_ready) begin
            if (req_valid) begin
              w_accept    = 1'b1;
              w_state_nxt = ST_RUN;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
`else
          if (rsp_ready) begin
            w_state_nxt = ST_IDLE;
          end
`endif
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_wide_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_wide_seq
//  Purpose  : Self-checking bench for alu_wide_seq (NUM_SLICES = 4). Contains
//             a behavioural 16-bit ALU (add for sel 1001 arithmetic, XOR for
//             sel 0110 logic) hooked to the ALU side of the sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_wide_seq;

  localparam int N = 4;
  localparam int W = 16 * N;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;
  logic [3:0]     req_sel;
  logic           req_mode;
  logic           req_carry_in;
  logic           alu_carry_in;
  logic [15:0]    alu_in_a;
  logic [15:0]    alu_in_b;
  logic [3:0]     alu_sel;
  logic           alu_mode;
  logic           alu_carry_out;
  logic           alu_compare;
  logic [15:0]    alu_result;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_result;
  logic           rsp_carry_out;
  logic           rsp_equal;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_wide_seq #(.NUM_SLICES(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_sel       (req_sel),
    .req_mode      (req_mode),
    .req_carry_in  (req_carry_in),
    .alu_carry_in  (alu_carry_in),
    .alu_in_a      (alu_in_a),
    .alu_in_b      (alu_in_b),
    .alu_sel       (alu_sel),
    .alu_mode      (alu_mode),
    .alu_carry_out (alu_carry_out),
    .alu_compare   (alu_compare),
    .alu_result    (alu_result),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_carry_out (rsp_carry_out),
    .rsp_equal     (rsp_equal)
  );

  // Behavioural 16-bit ALU slice.
  logic [16:0] w_sum;
  always_comb begin
    w_sum         = {1'b0, alu_in_a} + {1'b0, alu_in_b} + {16'd0, alu_carry_in};
    alu_result    = 16'h0000;
    alu_carry_out = 1'b0;
    alu_compare   = (alu_in_a == alu_in_b);
    if (!alu_mode && alu_sel == 4'b1001) begin
      alu_result    = w_sum[15:0];
      alu_carry_out = w_sum[16];
    end else if (alu_mode && alu_sel == 4'b0110) begin
      alu_result = alu_in_a ^ alu_in_b;
    end
  end

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   sel;
    logic         mode;
    logic         cin;
    logic [W-1:0] exp_res;
    logic         exp_co;
    logic         exp_eq;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic run_op(input vec_t v);
    int   lat;
    int   k;
    logic ci [N];
    for (int i = 0; i < N; i++) ci[i] = 1'bx;
    req_a        = v.a;
    req_b        = v.b;
    req_sel      = v.sel;
    req_mode     = v.mode;
    req_carry_in = v.cin;
    req_valid    = 1'b1;
    rsp_ready    = 1'b0;
    #3;
    k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #4;
      k++;
    end
    check({v.name, "_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    // Scramble the request inputs after acceptance; they must be ignored.
    req_valid    = 1'b0;
    req_a        = {$urandom, $urandom};
    req_b        = {$urandom, $urandom};
    req_sel      = 4'($urandom);
    req_mode     = 1'($urandom);
    req_carry_in = 1'($urandom);
    lat = 1;
    while (lat < 20) begin
      #3;
      if (rsp_valid) break;
      if (lat <= N) ci[lat-1] = alu_carry_in;
      @(posedge clk); #1;
      lat++;
    end
    check({v.name, "_latency"}, 64'(lat), 64'(N + 1));
    check({v.name, "_result"}, rsp_result, v.exp_res);
    check({v.name, "_carry"}, 64'(rsp_carry_out), 64'(v.exp_co));
    check({v.name, "_equal"}, 64'(rsp_equal), 64'(v.exp_eq));
    if (v.mode) begin
      check({v.name, "_ci0"}, 64'(ci[0]), 64'(v.cin));
      for (int i = 1; i < N; i++) check({v.name, "_ci_hi"}, 64'(ci[i]), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] held;
    int           k;

    vecs[0] = '{"add_ripple", 64'h0000_0000_0000_FFFF, 64'h1, 4'b1001, 1'b0, 1'b0,
                64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{"overflow", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'b1001, 1'b0, 1'b0,
                64'h0, 1'b1, 1'b0};
    vecs[2] = '{"xor_eq", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 4'b0110, 1'b1, 1'b1,
                64'h0, 1'b0, 1'b1};
    vecs[3] = '{"top_neq", 64'h0001_0000_0000_0000, 64'h0, 4'b1001, 1'b0, 1'b0,
                64'h0001_0000_0000_0000, 1'b0, 1'b0};
    vecs[4] = '{"cin_only", 64'h0, 64'h0, 4'b1001, 1'b0, 1'b1,
                64'h1, 1'b0, 1'b1};
    vecs[5] = '{"mid_ripple", 64'h0000_FFFF_FFFF_FFFF, 64'h1, 4'b1001, 1'b0, 1'b0,
                64'h0001_0000_0000_0000, 1'b0, 1'b0};
    vecs[6] = '{"xor_neq", 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 4'b0110, 1'b1, 1'b0,
                64'hF0F0_0F0F_F0F0_0F0F, 1'b0, 1'b0};
    vecs[7] = '{"add_gen", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 4'b1001, 1'b0, 1'b0,
                64'h2345_6789_ABCD_F001, 1'b0, 1'b0};
    vecs[8] = '{"add_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1001, 1'b0, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_sel = '0; req_mode = 1'b0; req_carry_in = 1'b0;

    // Reset state
    @(posedge clk); #3;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_result", rsp_result, 64'd0);
    check("rst_rsp_flags", 64'({rsp_carry_out, rsp_equal}), 64'd0);
    check("rst_alu_outs", 64'({alu_carry_in, alu_in_a, alu_in_b, alu_sel, alu_mode}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #3;
    check("post_rst_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // Backpressure with a pending new request
    req_a = vecs[0].a; req_b = vecs[0].b; req_sel = 4'b1001; req_mode = 1'b0;
    req_carry_in = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_a = vecs[7].a; req_b = vecs[7].b;
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    #3;
    check("bp_valid", 64'(rsp_valid), 64'd1);
    held = rsp_result;
    check("bp_first_result", held, vecs[0].exp_res);
    for (int c = 0; c < 3; c++) begin
      check("bp_hold_result", rsp_result, held);
      check("bp_hold_valid", 64'(rsp_valid), 64'd1);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      check("bp_alu_idle", 64'(alu_in_a), 64'd0);
      @(posedge clk); #4;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    #3;
`ifdef ALU_SEQ_PIPE_EN
    check("bp_release_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    #3;
    check("bp_next_valid", 64'(rsp_valid), 64'd0);
    check("bp_next_slice0", 64'(alu_in_a), 64'hDEF0);
`else
    check("bp_release_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    #3;
    check("bp_next_valid", 64'(rsp_valid), 64'd0);
    check("bp_idle_ready", 64'(req_ready), 64'd1);
    check("bp_idle_alu", 64'(alu_in_a), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    #3;
    check("bp_next_slice0", 64'(alu_in_a), 64'hDEF0);
`endif
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(posedge clk); #4;
      k++;
    end
    check("bp_second_valid", 64'(rsp_valid), 64'd1);
    check("bp_second_result", rsp_result, vecs[7].exp_res);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset during RUN after two slices have issued
    req_a = vecs[7].a; req_b = vecs[7].b; req_valid = 1'b1;
    #3;
    check("rr_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    #3;
    check("rr_slice0", 64'(alu_in_a), 64'hDEF0);
    @(posedge clk); #4;
    check("rr_slice1", 64'(alu_in_a), 64'h9ABC);
    @(posedge clk); #1;
    rst = 1'b1;
    #3;
    check("rr_alu_in_rst", 64'({alu_carry_in, alu_in_a, alu_in_b, alu_sel, alu_mode}), 64'd0);
    check("rr_ready_in_rst", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #3;
    check("rr_ready_after", 64'(req_ready), 64'd1);
    check("rr_alu_after", 64'({alu_carry_in, alu_in_a, alu_in_b, alu_sel, alu_mode}), 64'd0);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid) k++;
      @(posedge clk); #4;
    end
    check("rr_no_response", 64'(k), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_wide_seq.md
Name: alu_wide_seq

Overview:
Operation issuer that drives the 16-bit datapath ALU's input side and collects its outputs. It performs one wide (16*NUM_SLICES-bit) operation by issuing the slices least-significant first, one per cycle. Each slice's carry_out is fed back as the next slice's carry_in, and every slice result is captured. Requests arrive on a valid/ready port and results leave on a valid/ready port; the block sits between the core's execute control and the ALU.

Parameters:
NUM_SLICES, 4, number of 16-bit slices per operation (legal 1..8); the wide width W = 16*NUM_SLICES.

Ports:
clk  input  1  single clock, all logic rising-edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request.
req_a  input  W  operand A.
req_b  input  W  operand B.
req_sel  input  4  ALU function select, applied to every slice.
req_mode  input  1  0 = arithmetic, 1 = logic.
req_carry_in  input  1  carry into slice 0.
alu_carry_in  output  1  to ALU carry_in.
alu_in_a  output  16  to ALU in_a.
alu_in_b  output  16  to ALU in_b.
alu_sel  output  4  to ALU sel.
alu_mode  output  1  to ALU mode.
alu_carry_out  input  1  from ALU (combinational, same cycle).
alu_compare  input  1  from ALU, 1 when slice operands are equal.
alu_result  input  16  from ALU alu_out.
rsp_valid  output  1  result available.
rsp_ready  input  1  consumer accepts result.
rsp_result  output  W  assembled result, slice i in bits [16i+15:16i].
rsp_carry_out  output  1  carry out of the last slice (0 in logic mode).
rsp_equal  output  1  1 when req_a == req_b across all slices.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: FSM = IDLE, slice index = 0, req_ready = 0 during the reset cycle and 1 from the first cycle after rst deasserts. rsp_valid = 0; rsp_result, rsp_carry_out and rsp_equal = 0. All alu_* outputs = 0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - req_ready = 1.
  - When req_valid = 1: capture a, b, sel, mode and carry_in; set idx = 0, carry_reg = req_carry_in, eq_reg = 1; go to RUN.
- RUN:
  - req_ready = 0.
  - alu_in_a and alu_in_b drive slice idx of the captured operands; alu_sel and alu_mode drive the captured values; alu_carry_in = carry_reg.
  - At the clock edge:
    - result slice idx <= alu_result.
    - carry_reg <= alu_carry_out.
    - eq_reg <= eq_reg & alu_compare.
    - idx <= idx + 1.
  - When idx == NUM_SLICES-1, go to DONE instead of incrementing.
- DONE:
  - rsp_valid = 1; rsp_result, rsp_carry_out (= carry_reg) and rsp_equal (= eq_reg) are held stable until rsp_ready = 1.
  - When rsp_ready = 1, go to IDLE.
- alu_* outputs are 0 in every state other than RUN.
- Latency: request accepted at edge T; RUN occupies cycles T+1 .. T+NUM_SLICES; rsp_valid rises in cycle T+NUM_SLICES+1. Throughput without the optional feature is one operation per NUM_SLICES+2 cycles.
- Carry chaining is unconditional. In logic mode the ALU returns carry_out = 0, so carry_reg becomes 0 after slice 0. Whether chaining is meaningful depends on the function selected (true multi-word for sel 1001 add); the block does not special-case any function.
- req_* values are ignored outside the accepting cycle; changes to the inputs during RUN or DONE have no effect.
- Reset mid-RUN or mid-DONE: the operation is dropped with no response, and all state returns to the reset values.
- Backpressure: DONE may persist for any number of cycles; the response must not change while rsp_valid = 1 and rsp_ready = 0.

Optional Feature:
ALU_SEQ_PIPE_EN
- Defined: in DONE, req_ready = rsp_ready. When rsp_ready and req_valid are both 1 in the same cycle, the response completes and the new request is captured at the same edge, going directly to RUN. Back-to-back throughput is one operation per NUM_SLICES+1 cycles.
- Undefined: req_ready = 0 in DONE, and the FSM always passes through IDLE.

Test Plan:
- Add ripple, NUM_SLICES = 4:
  - Stimulus: sel = 1001, mode = 0, cin = 0, a = 0x0000_0000_0000_FFFF, b = 0x1.
  - Response: rsp_result = 0x0000_0000_0001_0000, rsp_carry_out = 0, rsp_equal = 0, and rsp_valid exactly 5 cycles after the accept edge.
- Full overflow:
  - Stimulus: sel = 1001, a = 0xFFFF_FFFF_FFFF_FFFF, b = 0x1, cin = 0.
  - Response: rsp_result = 0, rsp_carry_out = 1.
- Logic mode:
  - Stimulus: mode = 1, sel = 0110 (XOR), a = b = 0x1234_5678_9ABC_DEF0, cin = 1.
  - Response: rsp_result = 0, rsp_carry_out = 0, rsp_equal = 1, and alu_carry_in = 0 on slices 1-3.
- Inequality in the top slice only:
  - Stimulus: a = 0x0001_0000_0000_0000, b = 0.
  - Response: rsp_equal = 0.
- Backpressure:
  - Stimulus: hold rsp_ready = 0 for 3 cycles in DONE while req_valid = 1 with new operands.
  - Response: the response stays unchanged and req_ready = 0. After rsp_ready = 1, the next request is accepted per the macro setting: the same edge when ALU_SEQ_PIPE_EN is defined, otherwise one cycle later.
- Reset during RUN:
  - Stimulus: assert rst for 1 cycle after 2 slices have issued.
  - Response: rsp_valid never rises, alu_* outputs = 0, and req_ready = 1 on the cycle after rst deasserts.
